// File: rtl/bcd_rezultat.sv
`default_nettype none
// ============================================================================
// Module      : bcd_rezultat
// Description : Converts the finished result of an N-bit restoring divider
//               (quotient, remainder) into two 3-digit BCD words using a
//               sequential double-dabble engine. Each bit takes one ADJUST
//               cycle and one SHIFT cycle, so a conversion takes 2*(N+1)
//               clock edges after the capture edge.
// Revision    : 1.0 - initial release
//
// Parameters
//   N          : divider operand width (2..8)
//
// Ports
//   clk        : in   clock, rising edge
//   reset      : in   asynchronous active-low reset
//   ready_in   : in   divider ready flag; the rising edge starts a conversion
//   quotient   : in   [N-1:0] divider quotient, sampled on capture only
//   remainder  : in   [N:0]   divider remainder, sampled on capture only
//   bcd_q      : out  [11:0]  quotient as hundreds/tens/units BCD digits
//   bcd_r      : out  [11:0]  remainder as hundreds/tens/units BCD digits
//   valid      : out  high while bcd_q/bcd_r hold a completed conversion
//   busy       : out  high while a conversion is in progress
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits (hundreds, then
//                           tens if hundreds is blank) are shown as 4'hF.
//                           The units digit is never blanked.
// ============================================================================
module bcd_rezultat #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ready_in,
    input  logic [N-1:0] quotient,
    input  logic [N:0]   remainder,
    output logic [11:0]  bcd_q,
    output logic [11:0]  bcd_r,
    output logic         valid,
    output logic         busy
);

    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADJUST = 2'd1,
        S_SHIFT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           ready_q;                 // ready_in delayed by one cycle
    logic [N:0]     binq_q, binq_d;          // quotient binary shift register
    logic [N:0]     binr_q, binr_d;          // remainder binary shift register
    logic [11:0]    scrq_q, scrq_d;          // quotient BCD scratch
    logic [11:0]    scrr_q, scrr_d;          // remainder BCD scratch
    logic [CW-1:0]  cnt_q, cnt_d;            // bits still to shift
    logic [11:0]    resq_q, resq_d;
    logic [11:0]    resr_q, resr_d;

    logic           capture;
    logic [11:0]    shq, shr;

    // Double-dabble correction: each digit is adjusted on its own, a digit
    // >= 5 can reach at most 12, so no carry into the next digit is needed.
    function automatic logic [11:0] adjust3(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3
                                                 : v[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [11:0] fmt(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef LEADING_ZERO_BLANK_EN
        if (v[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (v[7:4] == 4'd0) begin
                r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    assign capture = ready_in & ~ready_q;

    // Scratch after this cycle's shift; used both for the register update and
    // for loading the outputs on the final shift.
    assign shq = {scrq_q[10:0], binq_q[N]};
    assign shr = {scrr_q[10:0], binr_q[N]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            binq_q  <= '0;
            binr_q  <= '0;
            scrq_q  <= '0;
            scrr_q  <= '0;
            cnt_q   <= '0;
            resq_q  <= 12'h000;
            resr_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            ready_q <= ready_in;
            binq_q  <= binq_d;
            binr_q  <= binr_d;
            scrq_q  <= scrq_d;
            scrr_q  <= scrr_d;
            cnt_q   <= cnt_d;
            resq_q  <= resq_d;
            resr_q  <= resr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        binq_d  = binq_q;
        binr_d  = binr_q;
        scrq_d  = scrq_q;
        scrr_d  = scrr_q;
        cnt_d   = cnt_q;
        resq_d  = resq_q;
        resr_d  = resr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (capture) begin
                    binq_d  = {1'b0, quotient};
                    binr_d  = remainder;
                    scrq_d  = '0;
                    scrr_d  = '0;
                    cnt_d   = CW'(N + 1);
                    state_d = S_ADJUST;
                end
            end
            S_ADJUST: begin
                scrq_d  = adjust3(scrq_q);
                scrr_d  = adjust3(scrr_q);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                scrq_d = shq;
                scrr_d = shr;
                binq_d = {binq_q[N-1:0], 1'b0};
                binr_d = {binr_q[N-1:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    resq_d  = fmt(shq);
                    resr_d  = fmt(shr);
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADJUST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bcd_q = resq_q;
    assign bcd_r = resr_q;
    assign valid = (state_q == S_DONE);
    assign busy  = (state_q == S_ADJUST) || (state_q == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_bcd_rezultat.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_rezultat
// Description : Directed self-checking bench for bcd_rezultat. Drives an N=4
//               instance through the main scenarios and an N=8 instance for
//               the wide-operand case. Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_rezultat;

    logic        clk;
    logic        reset;

    logic        rdy4;
    logic [3:0]  q4;
    logic [4:0]  r4;
    logic [11:0] bq4, br4;
    logic        v4, b4;

    logic        rdy8;
    logic [7:0]  q8;
    logic [8:0]  r8;
    logic [11:0] bq8, br8;
    logic        v8, b8;

    int n_checks;
    int n_fail;

    bcd_rezultat #(.N(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .ready_in  (rdy4),
        .quotient  (q4),
        .remainder (r4),
        .bcd_q     (bq4),
        .bcd_r     (br4),
        .valid     (v4),
        .busy      (b4)
    );

    bcd_rezultat #(.N(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .ready_in  (rdy8),
        .quotient  (q8),
        .remainder (r8),
        .bcd_q     (bq8),
        .bcd_r     (br8),
        .valid     (v8),
        .busy      (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected display form of a plain 3-digit BCD value in this build.
    function automatic logic [11:0] disp(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef LEADING_ZERO_BLANK_EN
        if (v[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (v[7:4] == 4'd0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // One-cycle ready pulse on the N=4 instance, then wait for valid.
    // The quotient/remainder inputs are scrambled after capture so any
    // resampling mid-conversion would corrupt the result.
    task automatic run4(input logic [3:0] q, input logic [4:0] r,
                        input logic [11:0] eq, input logic [11:0] er, input string tag);
        int cyc;
        @(negedge clk);
        q4 = q; r4 = r; rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0; q4 = ~q; r4 = ~r;
        check({tag, "_valid_drop"}, {31'd0, v4}, 32'd0);
        check({tag, "_busy"}, {31'd0, b4}, 32'd1);
        cyc = 0;
        while (!v4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd10);
        check({tag, "_bcd_q"}, {20'd0, bq4}, {20'd0, disp(eq)});
        check({tag, "_bcd_r"}, {20'd0, br4}, {20'd0, disp(er)});
        check({tag, "_busy_end"}, {31'd0, b4}, 32'd0);
    endtask

    task automatic run8(input logic [7:0] q, input logic [8:0] r,
                        input logic [11:0] eq, input logic [11:0] er, input string tag);
        int cyc;
        @(negedge clk);
        q8 = q; r8 = r; rdy8 = 1'b1;
        @(negedge clk);
        rdy8 = 1'b0; q8 = ~q; r8 = ~r;
        cyc = 0;
        while (!v8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd18);
        check({tag, "_bcd_q"}, {20'd0, bq8}, {20'd0, disp(eq)});
        check({tag, "_bcd_r"}, {20'd0, br8}, {20'd0, disp(er)});
    endtask

    initial begin
        int busy_cyc;
        int busy_rises;
        logic prev_b;
        int cyc;

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        rdy4 = 1'b0; q4 = '0; r4 = '0;
        rdy8 = 1'b0; q8 = '0; r8 = '0;

        repeat (3) @(negedge clk);
        check("rst_bcd_q", {20'd0, bq4}, 32'h000);
        check("rst_bcd_r", {20'd0, br4}, 32'h000);
        check("rst_valid", {31'd0, v4}, 32'd0);
        check("rst_busy",  {31'd0, b4}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_valid", {31'd0, v4}, 32'd0);

        // Basic and boundary conversions, N=4
        run4(4'd4,  5'd1,  12'h004, 12'h001, "q4r1");
        run4(4'd15, 5'd31, 12'h015, 12'h031, "max");
        run4(4'd0,  5'd0,  12'h000, 12'h000, "zero");
        run4(4'd4,  5'd0,  12'h004, 12'h000, "blank1");
        run4(4'd10, 5'd3,  12'h010, 12'h003, "blank2");

        // N=8 wide operands
        run8(8'd255, 9'd300, 12'h255, 12'h300, "n8a");
        run8(8'd0,   9'd511, 12'h000, 12'h511, "n8b");
        run8(8'd99,  9'd100, 12'h099, 12'h100, "n8c");

        // DONE holds its result while ready stays low
        repeat (5) @(negedge clk);
        check("hold_valid", {31'd0, v4}, 32'd1);
        check("hold_bcd_q", {20'd0, bq4}, {20'd0, disp(12'h010)});

        // ready_in held high for 40 cycles: exactly one 10-cycle busy pulse
        busy_cyc = 0; busy_rises = 0; prev_b = 1'b0;
        @(negedge clk);
        q4 = 4'd7; r4 = 5'd8; rdy4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b4) busy_cyc++;
            if (b4 && !prev_b) busy_rises++;
            prev_b = b4;
        end
        rdy4 = 1'b0;
        check("held_busy_pulses", busy_rises, 32'd1);
        check("held_busy_cycles", busy_cyc, 32'd10);
        check("held_valid", {31'd0, v4}, 32'd1);
        check("held_bcd_q", {20'd0, bq4}, {20'd0, disp(12'h007)});
        check("held_bcd_r", {20'd0, br4}, {20'd0, disp(12'h008)});

        // Second ready pulse mid-conversion is ignored
        @(negedge clk);
        q4 = 4'd6; r4 = 5'd2; rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        q4 = 4'd9; r4 = 5'd9; rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        cyc = 0;
        while (!v4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ign_bcd_q", {20'd0, bq4}, {20'd0, disp(12'h006)});
        check("ign_bcd_r", {20'd0, br4}, {20'd0, disp(12'h002)});
        repeat (3) @(negedge clk);
        check("ign_no_restart", {31'd0, b4}, 32'd0);

        // Restart from DONE
        run4(4'd15, 5'd3, 12'h015, 12'h003, "restart");

        // Asynchronous reset mid-conversion
        @(negedge clk);
        q4 = 4'd5; r4 = 5'd6; rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_bcd_q", {20'd0, bq4}, 32'h000);
        check("arst_bcd_r", {20'd0, br4}, 32'h000);
        check("arst_valid", {31'd0, v4}, 32'd0);
        check("arst_busy",  {31'd0, b4}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle_busy", {31'd0, b4}, 32'd0);
        run4(4'd12, 5'd27, 12'h012, 12'h027, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
